// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: opcodes, FSM states, lane widths
// and small opcode-classification helpers.
package load_store_unit_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LH  = 3'd1,
    OP_LW  = 3'd2,
    OP_SW  = 3'd3,
    OP_LBU = 3'd4,
    OP_LHU = 3'd5,
    OP_SB  = 3'd6,
    OP_SH  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  function automatic logic is_load(input op_e op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  // Byte and halfword stores need a read-modify-write of the containing word.
  function automatic logic is_sub_store(input op_e op);
    return (op == OP_SB) || (op == OP_SH);
  endfunction

  function automatic logic is_misaligned(input op_e op, input logic [1:0] off);
    logic bad;
    case (op)
      OP_LH, OP_LHU, OP_SH: bad = off[0];
      OP_LW, OP_SW:         bad = (off != 2'd0);
      default:              bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_lane_mux.sv
// Big-endian lane extract with sign/zero extension, and sub-word merge of
// store data into the current memory word.
module lsu_lane_mux
  import load_store_unit_pkg::*;
(
  input  op_e         op,
  input  logic [1:0]  off,
  input  logic [31:0] mem_rdata,
  input  logic [15:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_data
);

  logic [BYTE_W-1:0] byte_s;
  logic [HALF_W-1:0] half_s;

  // Offset 0 is the most significant lane.
  always_comb begin
    byte_s = 8'd0;
    case (off)
      2'd0:    byte_s = mem_rdata[31:24];
      2'd1:    byte_s = mem_rdata[23:16];
      2'd2:    byte_s = mem_rdata[15:8];
      2'd3:    byte_s = mem_rdata[7:0];
      default: byte_s = 8'd0;
    endcase
    if (off[1]) begin
      half_s = mem_rdata[15:0];
    end else begin
      half_s = mem_rdata[31:16];
    end
  end

  // Load result extension.
  always_comb begin
    load_data = 32'd0;
    case (op)
      OP_LB:   load_data = {{(WORD_W-BYTE_W){byte_s[BYTE_W-1]}}, byte_s};
      OP_LBU:  load_data = {{(WORD_W-BYTE_W){1'b0}}, byte_s};
      OP_LH:   load_data = {{(WORD_W-HALF_W){half_s[HALF_W-1]}}, half_s};
      OP_LHU:  load_data = {{(WORD_W-HALF_W){1'b0}}, half_s};
      OP_LW:   load_data = mem_rdata;
      default: load_data = 32'd0;
    endcase
  end

  // Store merge: replace only the addressed lane.
  always_comb begin
    merged_data = mem_rdata;
    case (op)
      OP_SB: begin
        case (off)
          2'd0:    merged_data[31:24] = store_data[7:0];
          2'd1:    merged_data[23:16] = store_data[7:0];
          2'd2:    merged_data[15:8]  = store_data[7:0];
          2'd3:    merged_data[7:0]   = store_data[7:0];
          default: merged_data = mem_rdata;
        endcase
      end
      OP_SH: begin
        if (off[1]) begin
          merged_data[15:0] = store_data;
        end else begin
          merged_data[31:16] = store_data;
        end
      end
      default: merged_data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single-request FSM between the CPU and a word-organised
// data memory with combinational read and clocked write.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

  state_e            state_r;
  op_e               op_r;
  op_e               op_in_s;
  logic [1:0]        off_r;
  logic [15:0]       wdata_r;
  logic              ready_r;
  logic              done_r;
  logic              err_r;
  logic [31:0]       rdata_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [31:0]       mem_wdata_r;
  logic              mem_we_r;
  logic [31:0]       load_s;
  logic [31:0]       merged_s;

  assign op_in_s = op_e'(op);

  lsu_lane_mux u_lane_mux (
    .op          (op_r),
    .off         (off_r),
    .mem_rdata   (mem_rdata),
    .store_data  (wdata_r),
    .load_data   (load_s),
    .merged_data (merged_s)
  );

  // Control FSM; every output is a register so the async reset clears
  // mem_we immediately, cancelling a store caught in WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      op_r        <= OP_LB;
      off_r       <= 2'd0;
      wdata_r     <= 16'd0;
      ready_r     <= 1'b1;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      rdata_r     <= 32'd0;
      mem_addr_r  <= '0;
      mem_wdata_r <= 32'd0;
      mem_we_r    <= 1'b0;
    end else begin
      done_r   <= 1'b0;
      mem_we_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req) begin
            op_r       <= op_in_s;
            off_r      <= addr_in[1:0];
            wdata_r    <= wdata[15:0];
            mem_addr_r <= addr_in >> 2;
            ready_r    <= 1'b0;
            if (is_misaligned(op_in_s, addr_in[1:0])) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
              err_r   <= 1'b1;
            end else begin
              state_r <= ST_ACCESS;
              err_r   <= 1'b0;
              // Full-word stores need no read, so write during ACCESS.
              if (op_in_s == OP_SW) begin
                mem_we_r    <= 1'b1;
                mem_wdata_r <= wdata;
              end else begin
                mem_wdata_r <= mem_wdata_r;
              end
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (is_sub_store(op_r)) begin
            mem_wdata_r <= merged_s;
            mem_we_r    <= 1'b1;
            state_r     <= ST_WRITE;
          end else begin
            if (is_load(op_r)) begin
              rdata_r <= load_s;
            end else begin
              rdata_r <= rdata_r;
            end
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end
        end
        ST_WRITE: begin
          state_r <= ST_DONE;
          done_r  <= 1'b1;
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b1;
          err_r   <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b1;
          err_r   <= 1'b0;
        end
      endcase
    end
  end

  assign ready     = ready_r;
  assign done      = done_r;
  assign err       = err_r;
  assign rdata     = rdata_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_we    = mem_we_r;

endmodule
